// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the LEGv8 control path: states, instruction classes,
// opcode patterns with don't-care masks, and datapath mux encodings.
package cpu_defs_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
   } state_e;

   typedef enum logic [3:0] {
      C_R, C_ADDI, C_LD, C_ST, C_CB_Z, C_CB_NZ, C_B, C_HALT, C_ILLEGAL
   } iclass_e;

   // A mask bit of 0 marks an opcode bit that belongs to the immediate field
   localparam logic [10:0] OP_ADD   = 11'b10001011000, MSK_ADD   = 11'b11111111111;
   localparam logic [10:0] OP_SUB   = 11'b11001011000, MSK_SUB   = 11'b11111111111;
   localparam logic [10:0] OP_AND   = 11'b10001010000, MSK_AND   = 11'b11111111111;
   localparam logic [10:0] OP_ORR   = 11'b10101010000, MSK_ORR   = 11'b11111111111;
   localparam logic [10:0] OP_ADDI  = 11'b10010001000, MSK_ADDI  = 11'b11111111110;
   localparam logic [10:0] OP_LDUR  = 11'b11111000010, MSK_LDUR  = 11'b11111111111;
   localparam logic [10:0] OP_STUR  = 11'b11111000000, MSK_STUR  = 11'b11111111111;
   localparam logic [10:0] OP_CBZ   = 11'b10110100000, MSK_CBZ   = 11'b11111111000;
   localparam logic [10:0] OP_CBNZ  = 11'b10110101000, MSK_CBNZ  = 11'b11111111000;
   localparam logic [10:0] OP_B     = 11'b00010100000, MSK_B     = 11'b11111100000;
   localparam logic [10:0] OP_HALT  = 11'b11111111111, MSK_HALT  = 11'b11111111111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_DIMM = 2'b01;
   localparam logic [1:0] SRCB_AIMM = 2'b10;
   localparam logic [1:0] SRCB_FOUR = 2'b11;

   localparam logic PCSRC_ALU = 1'b0;
   localparam logic PCSRC_BR  = 1'b1;

   function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                     input logic [10:0] msk);
      return ((op ^ pat) & msk) == 11'b0;
   endfunction

endpackage

// File: rtl/cpu_opcode_class.sv
// Combinational opcode classifier; shared with the single-cycle control.
module cpu_opcode_class
   import cpu_defs_pkg::*;
(
   input  logic [10:0] opcode,
   output iclass_e     cls
);

   always_comb begin
      cls = C_ILLEGAL;
      if (op_match(opcode, OP_ADD, MSK_ADD) || op_match(opcode, OP_SUB, MSK_SUB) ||
          op_match(opcode, OP_AND, MSK_AND) || op_match(opcode, OP_ORR, MSK_ORR))
         cls = C_R;
      else if (op_match(opcode, OP_ADDI, MSK_ADDI)) cls = C_ADDI;
      else if (op_match(opcode, OP_LDUR, MSK_LDUR)) cls = C_LD;
      else if (op_match(opcode, OP_STUR, MSK_STUR)) cls = C_ST;
      else if (op_match(opcode, OP_CBZ,  MSK_CBZ))  cls = C_CB_Z;
      else if (op_match(opcode, OP_CBNZ, MSK_CBNZ)) cls = C_CB_NZ;
      else if (op_match(opcode, OP_B,    MSK_B))    cls = C_B;
      else if (op_match(opcode, OP_HALT, MSK_HALT)) cls = C_HALT;
   end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: state and class registers, next-state logic,
// and a Moore output decode (plus mem_ready/zero-qualified PC/IR strobes).
module cpu_multicycle_ctrl
   import cpu_defs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        Reg2Loc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        PCSource,
   output logic        IorD,
   output logic        halted,
   output logic        illegal
);

   state_e  state_q, state_d;
   iclass_e cls_q, cls_d, cls_dec;

   cpu_opcode_class u_class (
      .opcode (opcode),
      .cls    (cls_dec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cls_q   <= C_ILLEGAL;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   end

   // Class is captured only in DECODE so later opcode changes cannot leak in
   always_comb begin
      cls_d   = (state_q == S_DECODE) ? cls_dec : cls_q;
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (cls_dec)
               C_R, C_ADDI, C_LD, C_ST: state_d = S_EXEC;
               C_CB_Z, C_CB_NZ, C_B:    state_d = S_BRANCH;
               C_HALT:                  state_d = S_HALT;
               default:                 state_d = S_FETCH;
            endcase
         end
         S_EXEC:   state_d = (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
         S_MEM:    if (mem_ready) state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_REG;
      ALUOp    = ALUOP_ADD;
      PCSource = PCSRC_ALU;
      IorD     = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            PCWrite = mem_ready;
            IRWrite = mem_ready;
         end
         S_DECODE: illegal = (cls_dec == C_ILLEGAL);
         S_EXEC: begin
            ALUSrcA = 1'b1;
            case (cls_q)
               C_R:    begin ALUSrcB = SRCB_REG;  ALUOp = ALUOP_FUNCT; end
               C_ADDI: begin ALUSrcB = SRCB_AIMM; ALUOp = ALUOP_FUNCT; end
               C_LD:   ALUSrcB = SRCB_DIMM;
               C_ST:   begin ALUSrcB = SRCB_DIMM; Reg2Loc = 1'b1; end
               default: ;
            endcase
         end
         S_MEM: begin
            IorD     = 1'b1;
            MemRead  = (cls_q == C_LD);
            MemWrite = (cls_q == C_ST);
            Reg2Loc  = (cls_q == C_ST);
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (cls_q == C_LD);
         end
         S_BRANCH: begin
            Reg2Loc  = 1'b1;
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_PASSB;
            PCSource = PCSRC_BR;
            PCWrite  = (cls_q == C_B) || (cls_q == C_CB_Z && zero) ||
                       (cls_q == C_CB_NZ && !zero);
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule
